// File: rtl/shift_rows_stage.sv
// Registered AES ShiftRows / InvShiftRows stage. The row rotation is applied
// as a state is written into a 2-entry elastic buffer that feeds MixColumns.
module shift_rows_stage #(
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0][3:0][7:0]   in_state,
    input  logic                   in_inv,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0][3:0][7:0]   out_state,
    output logic [TAG_W-1:0]       out_tag,
    output logic [1:0]             occupancy
);

    typedef logic [3:0][3:0][7:0] state_t;

    state_t           buf_state [2];
    logic [TAG_W-1:0] buf_tag   [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;
    logic [1:0]       occ_next;
    logic             in_ready_q;
    logic             push;
    logic             pop;
    state_t           rot_state;

    // Column index arithmetic is 2-bit, so the mod-4 wrap comes for free.
    always_comb begin
        rot_state = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                logic [1:0] fwd_col;
                logic [1:0] inv_col;
                fwd_col = 2'(c + r);
                inv_col = 2'(c - r);
                rot_state[r][c] = in_inv ? in_state[r][inv_col]
                                         : in_state[r][fwd_col];
            end
        end
    end

    assign push = in_valid & in_ready_q;
    assign pop  = (occ != 2'd0) & out_ready;

    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_state[0] <= '0;
            buf_state[1] <= '0;
            buf_tag[0]   <= '0;
            buf_tag[1]   <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            occ          <= 2'd0;
            in_ready_q   <= 1'b0;
        end else begin
            if (push) begin
                buf_state[wr_ptr] <= rot_state;
                buf_tag[wr_ptr]   <= in_tag;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ        <= occ_next;
            // Registered ready keeps in_valid/out_ready off every output path.
            in_ready_q <= (occ_next != 2'd2);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (occ != 2'd0);
    assign out_state = buf_state[rd_ptr];
    assign out_tag   = buf_tag[rd_ptr];
    assign occupancy = occ;

endmodule

// File: doc/shift_rows_stage.md
Name: shift_rows_stage

Overview:
- Registered AES ShiftRows / InvShiftRows stage, directly downstream of the S-box substitution stage.
- Consumes the substituted 4x4 byte state and applies the cyclic row rotation.
- Presents the result to the MixColumns stage through a 2-entry elastic buffer with valid/ready handshakes on both sides.
- Carries a sideband tag alongside the data so downstream logic can identify the final round.

Parameters:
- TAG_W, 4, width of the sideband tag carried with each state (round number / flags); must be >= 1.

Ports:
- clk  input  1  stage clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has a state on in_state/in_inv/in_tag.
- in_ready  output  1  stage can accept a state this cycle.
- in_state  input  8 x [3:0][3:0]  substituted state, indexed [row][col], byte FIPS-197 s(r,c).
- in_inv  input  1  1 = InvShiftRows, 0 = ShiftRows; sampled with the state.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  out_state/out_tag hold a valid transformed state.
- out_ready  input  1  downstream accepts the state this cycle.
- out_state  output  8 x [3:0][3:0]  rotated state, [row][col].
- out_tag  output  TAG_W  tag of the state on out_state.
- occupancy  output  2  number of buffered states, 0..2.

Behaviour:
- Reset: clk is the single clock domain; resetn is asynchronous, active-low.
  - On resetn=0: out_valid=0, in_ready=0, occupancy=0, out_state=0, out_tag=0, both buffer entries cleared, read/write pointers=0.
  - After deassertion, in_ready=1 from the first clock edge onward.
- Transform, applied at write time, combinational on the input side:
  - in_inv=0: out[r][c] = in[r][(c+r) mod 4].
  - in_inv=1: out[r][c] = in[r][(c-r) mod 4].
  - Row 0 is never rotated. Column index arithmetic is 2-bit and wraps naturally.
- Handshakes:
  - Push when in_valid & in_ready at a rising edge.
  - Pop when out_valid & out_ready at a rising edge.
  - in_ready = (occupancy < 2), registered: it depends only on state, never on in_valid or out_ready.
  - out_valid = (occupancy != 0).
  - out_state/out_tag always show the entry at the read pointer (head). They are stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - A state pushed at edge N appears on out_state with out_valid=1 immediately after edge N (1-cycle latency).
  - Sustained throughput is 1 state/cycle when out_ready=1.
- Buffer: 2-entry circular buffer; 1-bit read and write pointers toggle on pop and push respectively.
  - Push only: occupancy+1.
  - Pop only: occupancy-1.
  - Push and pop together (possible only at occupancy 1): occupancy unchanged, head advances to the new entry.
  - occupancy 2: in_ready=0; in_valid is ignored and upstream holds.
  - Pop at occupancy 2: in_ready=1 after that edge.
  - occupancy 0: out_valid=0, out_ready is ignored, and out_state holds its last value (don't-care).
- Mode: in_inv and in_tag are latched per entry, so encrypt and decrypt states may interleave back-to-back.
- Reset mid-operation: all buffered states are discarded, with no partial output. The first state accepted after reset is the first state delivered.
- No combinational path from in_valid or out_ready to any output.

Test Plan:
- Forward vector: push state rows {d4 e0 b8 1e / 27 bf b4 41 / 11 98 5d 52 / ae f1 e5 30}, in_inv=0, tag=1, out_ready=1.
  - Required: next cycle out_state rows {d4 e0 b8 1e / bf b4 41 27 / 5d 52 11 98 / 30 ae f1 e5}, out_tag=1.
- Inverse round-trip: push that output with in_inv=0 feeding back as in_inv=1.
  - Required: the original rows are returned exactly; row 0 is unchanged in both directions.
- Backpressure: out_ready=0, push three consecutive states A, B, C with in_valid held.
  - Required: A and B accepted, occupancy=2, in_ready=0, C held off, out_state=A stable.
  - Then raise out_ready: outputs A, B, C in order, one per cycle; C is accepted the cycle after A pops.
- Full throughput: in_valid=1 and out_ready=1 for 16 cycles with distinct tags 0..15.
  - Required: occupancy stays 1, 16 outputs in order, no bubbles after the first.
- Interleaved modes: alternate in_inv=0/1 on the same input state.
  - Required: outputs alternate between the forward and inverse rotations, each matching its own latched in_inv.
- Async reset mid-stream: occupancy=2, assert resetn low between edges.
  - Required: out_valid, in_ready and occupancy go to 0 immediately without a clock.
  - After release: the first pushed state emerges next, with no stale A/B.
